// File: rtl/wave_readout.sv
// wave_readout: sweeps one half of the ping-pong waveform RAM into 255 line segments; define WAVE_READOUT_SCALE_EN to halve and offset samples by Y_OFFSET
module wave_readout #(
  parameter logic [7:0] Y_OFFSET = 8'd64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       read_index,
  input  logic [7:0] read_value,
  input  logic       pix_ready,
  output logic [8:0] read_address,
  output logic       wave_display_idle,
  output logic       pix_valid,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y_prev,
  output logic [7:0] pix_y_curr,
  output logic       frame_done
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, EMIT, DONE} state_t;
  state_t     state;
  logic       half;
  logic [7:0] idx;
  logic [7:0] y;
  logic       unused_bit;
`ifdef WAVE_READOUT_SCALE_EN
  assign y          = {1'b0, read_value[7:1]} + Y_OFFSET;
  assign unused_bit = read_value[0];
`else
  assign y          = read_value;
  assign unused_bit = ^Y_OFFSET;
`endif
  // sweep sequencer: fetch/capture each sample, hand out a segment, hold it until accepted
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state             <= IDLE;
      half              <= 1'b0;
      idx               <= 8'd0;
      read_address      <= 9'd0;
      wave_display_idle <= 1'b1;
      pix_valid         <= 1'b0;
      pix_x             <= 8'd0;
      pix_y_prev        <= 8'd0;
      pix_y_curr        <= 8'd0;
      frame_done        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE:
          if (frame_start) begin
            half              <= read_index;
            idx               <= 8'd0;
            read_address      <= {read_index, 8'd0};
            wave_display_idle <= 1'b0;
            state             <= FETCH;
          end
        FETCH: state <= CAPTURE;
        CAPTURE: begin
          pix_y_curr <= y;
          if (idx == 8'd0) begin
            idx          <= 8'd1;
            read_address <= {half, 8'd1};
            state        <= FETCH;
          end else begin
            pix_y_prev <= pix_y_curr;
            pix_x      <= idx;
            pix_valid  <= 1'b1;
            state      <= EMIT;
          end
        end
        EMIT:
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (idx == 8'd255) begin
              frame_done        <= 1'b1;
              wave_display_idle <= 1'b1;
              state             <= DONE;
            end else begin
              idx          <= idx + 8'd1;
              read_address <= {half, idx + 8'd1};
              state        <= FETCH;
            end
          end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/wave_readout.md
# wave_readout

Display-side reader for the ping-pong waveform RAM filled by the capture path. On each frame start it latches the read-half select and sweeps that half's 256 eight-bit samples. It emits 255 line segments (x, previous y, current y) to the pixel drawer over a valid/ready handshake. It drives `wave_display_idle` so the capture side only swaps halves between frames.

## Interface
Parameters:
- `Y_OFFSET`, default 8'd64: vertical offset added to scaled samples; used only when `WAVE_READOUT_SCALE_EN` is defined.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse requesting a sweep; honoured only in IDLE.
- `read_index`  in  1  RAM half to read; from the capture block.
- `read_value`  in  8  synchronous RAM data; valid the cycle after `read_address` is presented.
- `pix_ready`  in  1  drawer accepts the current segment.
- `read_address`  out  9  {latched half, sample index}.
- `wave_display_idle`  out  1  high when no sweep is in progress.
- `pix_valid`  out  1  segment outputs valid.
- `pix_x`  out  8  segment x, 1..255.
- `pix_y_prev`  out  8  y of sample x-1.
- `pix_y_curr`  out  8  y of sample x.
- `frame_done`  out  1  one-cycle pulse at end of sweep.

## Operation
- Reset values: state IDLE; `read_address`=0, `wave_display_idle`=1, `pix_valid`=0, `pix_x`=0, `pix_y_prev`=0, `pix_y_curr`=0, `frame_done`=0; latched half=0; index=0.
- All outputs are registered.
- **IDLE**: `wave_display_idle`=1.
  - On `frame_start`: latch half←`read_index`, index←0, `read_address`←{`read_index`,8'd0}, `wave_display_idle`←0, go to FETCH.
- **FETCH** (1 cycle): RAM samples `read_address`. Go to CAPTURE.
- **CAPTURE** (1 cycle): `read_value` is valid.
  - index==0: `pix_y_curr`←y(value), index←1, `read_address`←{half,1}, go to FETCH.
  - index>0: `pix_y_prev`←`pix_y_curr`, `pix_y_curr`←y(value), `pix_x`←index, `pix_valid`←1, go to EMIT.
- **EMIT**: hold all pix outputs while `pix_valid` && !`pix_ready`.
  - On the accept edge: `pix_valid`←0.
  - If index==255, go to DONE.
  - Otherwise index←index+1, `read_address`←{half,index+1}, go to FETCH.
- **DONE** (1 cycle): `frame_done`=1, `wave_display_idle`←1, go to IDLE.
- Address arithmetic: the index is 8-bit and never wraps within a frame. The top address bit is the latched half, never live `read_index`.
- Boundary rules:
  - `frame_start` outside IDLE, including in DONE, is ignored and not queued.
  - `read_index` changes mid-sweep have no effect.
  - `pix_ready` high while `pix_valid` is low is ignored.
  - Asserting `reset` at any point returns all outputs to reset values immediately.

## Timing
- `frame_start` at edge t: `wave_display_idle` falls and `read_address`={half,0} after edge t.
- First `pix_valid` rises after edge t+4 (FETCH, CAPTURE, FETCH, CAPTURE).
- With `pix_ready` held high, each segment costs 3 cycles (FETCH, CAPTURE, EMIT).
- Unstalled frame: 768 cycles from leaving IDLE to returning to IDLE (2 + 255×3 + 1 DONE).
- Each cycle of `pix_ready` low in EMIT adds exactly one cycle.
- `frame_done` and the rise of `wave_display_idle` occur on the same edge. `frame_done` lasts one cycle.

## Configuration
- `WAVE_READOUT_SCALE_EN` defined: y(v) = {1'b0, v[7:1]} + `Y_OFFSET`, computed in 8 bits modulo 256. This places the trace in a 128-line band.
- Macro undefined: y(v) = v unchanged, and `Y_OFFSET` is unused.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle. All outputs must match the reset values before the next edge; `wave_display_idle`=1.
- Full frame: half 1 loaded with mem[256+i]=i, `read_index`=1, `pix_ready`=1, pulse `frame_start`.
  - Addresses run 256..511.
  - Segments (x, x-1, x) for x=1..255.
  - `frame_done` fires 768 cycles after the sweep starts.
- Stall: drop `pix_ready` for 5 cycles while `pix_x`=10. `pix_x`=10, `pix_y_prev`=9, `pix_y_curr`=10 and `read_address` must stay stable. The frame lengthens to exactly 773 cycles.
- Half swap and extra start: toggle `read_index` at segment 100 and pulse `frame_start` at segment 150. `read_address`[8] stays at the latched value, and exactly 255 segments and one `frame_done` occur.
- Reset mid-frame at segment 40: `pix_valid`=0, state IDLE, `wave_display_idle`=1. A following `frame_start` produces a clean full frame.
- Scaling, with `WAVE_READOUT_SCALE_EN` defined and `Y_OFFSET`=64: samples 0x00, 0xFF, 0x80 produce y values 64, 191, 128. With the macro undefined they produce 0, 255, 128.
